nand_resp_checker: RTL and testbench
====================================

# nand_resp_checker

Synthesizable response checker for the `nand_gate` block, and the receiving end of its stimulus stream. Each cycle a producer can present a sampled (A_i, B_i, F_i) triple. The checker compares F_i against the NAND of A_i and B_i, counts checks and mismatches, captures the first failing triple, and tracks which of the four input combinations were exercised. At the end of a run it reports a single registered pass/fail verdict, so gate tests can self-check in simulation or on hardware.

## Interface

- CNT_W, default 8: width of the check and error counters; both saturate at 2^CNT_W-1.

- clk_i  input  1  sole clock; all state updates on the rising edge.
- rst_n_i  input  1  reset, asynchronous and active-low.
- start_i  input  1  begin a run; clears all results.
- stop_i  input  1  end a run; the verdict becomes valid.
- valid_i  input  1  the A_i/B_i/F_i triple is valid this cycle.
- A_i  input  1  gate input A as applied to the DUT.
- B_i  input  1  gate input B as applied to the DUT.
- F_i  input  1  observed gate output.
- busy_o  output  1  high while in RUN.
- done_o  output  1  high while in DONE.
- pass_o  output  1  verdict; meaningful only while done_o is high.
- cov_o  output  4  coverage bitmap; bit {A_i,B_i} is set once that combination is checked.
- chk_cnt_o  output  CNT_W  number of valid samples checked.
- err_cnt_o  output  CNT_W  number of mismatching samples.
- first_err_vld_o  output  1  first_err_o holds a captured mismatch.
- first_err_o  output  3  {A_i,B_i,F_i} of the first mismatch.

## Operation

- The FSM has three states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - start_i moves to RUN.
  - stop_i and valid_i are ignored.
- RUN:
  - Each cycle with valid_i=1:
    - Compute expected = ~(A_i & B_i).
    - Increment chk_cnt.
    - Set cov bit {A_i,B_i}.
    - If F_i != expected:
      - Increment err_cnt.
      - If first_err_vld_o=0, capture {A_i,B_i,F_i} and set first_err_vld_o.
  - stop_i moves to DONE. A valid_i sample in the same cycle is still checked and counted.
  - start_i is ignored in RUN. If start_i and stop_i are asserted together, the FSM goes to DONE.
- DONE:
  - Results hold.
  - valid_i and stop_i are ignored.
  - start_i moves to RUN and clears results.
- Start clear: on the cycle start_i is accepted (IDLE→RUN or DONE→RUN), these are cleared:
  - chk_cnt, err_cnt, cov, first_err_vld_o, first_err_o.
  - A valid_i asserted in that same cycle is not checked.
- Verdict: pass_o = (err_cnt_o==0) && (cov_o==4'hF). It is registered on entry to DONE and held until the next start. It is forced to 0 outside DONE.
- Saturation:
  - The counters stop at all-ones and never wrap.
  - When chk_cnt is saturated, cov and first-error capture continue to update.
  - When err_cnt is saturated, pass_o stays 0.
- X or Z on A_i/B_i/F_i while valid_i=1 is a bench error. No special RTL handling is required.

## Timing

- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset values:
  - busy_o=0, done_o=0, pass_o=0.
  - cov_o=4'h0, chk_cnt_o=0, err_cnt_o=0.
  - first_err_vld_o=0, first_err_o=3'b000.
- Sample latency: a valid_i sampled at edge N is reflected in the counters, cov_o and first_err_o after edge N.
- start_i sampled at edge N: busy_o=1 and results cleared after edge N. A valid_i at edge N+1 is the first sample checked.
- stop_i sampled at edge N:
  - busy_o=0, done_o=1, and pass_o valid after edge N.
  - The verdict includes any sample taken at edge N.
- Reset asserted mid-run: all outputs drop to their reset values immediately (asynchronously), without waiting for a clock edge. The FSM returns to IDLE and no partial verdict is kept.
- Throughput: one sample per cycle with no back-pressure, so there is no ready signal.

## Test plan

- **Full truth table:** start; valid triples (0,0,1), (1,0,1), (0,1,1), (1,1,0) on consecutive cycles; stop.
  - Expect chk_cnt_o=4, err_cnt_o=0, cov_o=4'hF, pass_o=1, done_o=1 one cycle after stop.
- **Wrong gate (OR behaviour):** triples (0,0,0), (1,0,1), (0,1,1), (1,1,1); stop.
  - Expect err_cnt_o=2, first_err_vld_o=1, first_err_o=3'b000, pass_o=0.
- **Incomplete coverage:** correct triples for (0,0) and (1,1) only; stop.
  - Expect cov_o=4'b1001, err_cnt_o=0, pass_o=0.
- **Saturation (CNT_W=4):** 20 mismatching samples with (1,1,1).
  - Expect err_cnt_o=chk_cnt_o=4'hF, no wrap, pass_o=0.
  - A restart with start_i clears both to 0.
- **Boundary cycles:**
  - start_i together with valid_i in IDLE: the sample is not counted (chk_cnt_o=0).
  - start_i and stop_i together in RUN: DONE is entered.
  - valid_i together with stop_i: the sample is counted.
- **Reset mid-run:** after 2 samples, pulse rst_n_i low between clock edges.
  - Expect all outputs at their reset values before the next edge and the FSM in IDLE.
  - A subsequent full run passes.

Source files
------------

// File: rtl/nand_resp_checker_if.sv
// Sample stream and run control from a gate-test producer into the checker.
// Latency: none (wires only).
// Backpressure: none; the consumer accepts one triple per cycle.
interface nand_resp_checker_if;
   logic start_i;
   logic stop_i;
   logic valid_i;
   logic A_i;
   logic B_i;
   logic F_i;

   modport master (
      output start_i, stop_i, valid_i, A_i, B_i, F_i
   );

   modport slave (
      input start_i, stop_i, valid_i, A_i, B_i, F_i
   );
endinterface

// File: rtl/nand_resp_checker.sv
// Checks observed NAND outputs, counts checks/errors, tracks coverage, gives a verdict.
// Latency: a sample or control input at edge N is reflected on the outputs after edge N.
// Backpressure: none; one sample per cycle is always accepted while running.
module nand_resp_checker #(
   parameter int CNT_W = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   nand_resp_checker_if.slave     s,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   pass_o,
   output logic [3:0]             cov_o,
   output logic [CNT_W-1:0]       chk_cnt_o,
   output logic [CNT_W-1:0]       err_cnt_o,
   output logic                   first_err_vld_o,
   output logic [2:0]             first_err_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state;
   logic             hit;
   logic             mis;
   logic [CNT_W-1:0] chk_nxt;
   logic [CNT_W-1:0] err_nxt;
   logic [3:0]       cov_nxt;

   // Result values after this cycle's sample; only meaningful while running.
   always_comb begin
      hit     = (state == RUN) && s.valid_i;
      mis     = hit && (s.F_i != ~(s.A_i & s.B_i));
      chk_nxt = chk_cnt_o;
      err_nxt = err_cnt_o;
      cov_nxt = cov_o;
      if (hit) begin
         cov_nxt = cov_o | (4'b0001 << {s.A_i, s.B_i});
         if (chk_cnt_o != CNT_MAX) begin
            chk_nxt = chk_cnt_o + CNT_W'(1);
         end
      end
      if (mis && (err_cnt_o != CNT_MAX)) begin
         err_nxt = err_cnt_o + CNT_W'(1);
      end
   end

   // Run FSM with all results and status held in registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state           <= IDLE;
         busy_o          <= 1'b0;
         done_o          <= 1'b0;
         pass_o          <= 1'b0;
         cov_o           <= 4'h0;
         chk_cnt_o       <= '0;
         err_cnt_o       <= '0;
         first_err_vld_o <= 1'b0;
         first_err_o     <= 3'b000;
      end else begin
         case (state)
            IDLE, DONE: begin
               // A sample arriving with start is dropped; results restart clean.
               if (s.start_i) begin
                  state           <= RUN;
                  busy_o          <= 1'b1;
                  done_o          <= 1'b0;
                  pass_o          <= 1'b0;
                  cov_o           <= 4'h0;
                  chk_cnt_o       <= '0;
                  err_cnt_o       <= '0;
                  first_err_vld_o <= 1'b0;
                  first_err_o     <= 3'b000;
               end
            end
            RUN: begin
               chk_cnt_o <= chk_nxt;
               err_cnt_o <= err_nxt;
               cov_o     <= cov_nxt;
               if (mis && !first_err_vld_o) begin
                  first_err_vld_o <= 1'b1;
                  first_err_o     <= {s.A_i, s.B_i, s.F_i};
               end
               // Stop wins over start; the verdict includes this cycle's sample.
               if (s.stop_i) begin
                  state  <= DONE;
                  busy_o <= 1'b0;
                  done_o <= 1'b1;
                  pass_o <= (err_nxt == '0) && (cov_nxt == 4'hF);
               end
            end
            default: begin
               state  <= IDLE;
               busy_o <= 1'b0;
               done_o <= 1'b0;
               pass_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nand_resp_checker.sv
// Bench for nand_resp_checker: directed table, corner sequences, random run vs model.
// Latency: outputs are compared 1 time unit after each rising edge.
// Backpressure: none; a stimulus record is driven every cycle.
module tb_nand_resp_checker;

   logic       clk_i;
   logic       rst_n_i;

   nand_resp_checker_if sif ();

   logic       busy8, done8, pass8, fev8;
   logic [3:0] cov8;
   logic [7:0] chk8, err8;
   logic [2:0] fe8;

   logic       busy4, done4, pass4, fev4;
   logic [3:0] cov4;
   logic [3:0] chk4, err4;
   logic [2:0] fe4;

   nand_resp_checker #(.CNT_W(8)) dut8 (
      .clk_i           (clk_i),
      .rst_n_i         (rst_n_i),
      .s               (sif.slave),
      .busy_o          (busy8),
      .done_o          (done8),
      .pass_o          (pass8),
      .cov_o           (cov8),
      .chk_cnt_o       (chk8),
      .err_cnt_o       (err8),
      .first_err_vld_o (fev8),
      .first_err_o     (fe8)
   );

   nand_resp_checker #(.CNT_W(4)) dut4 (
      .clk_i           (clk_i),
      .rst_n_i         (rst_n_i),
      .s               (sif.slave),
      .busy_o          (busy4),
      .done_o          (done4),
      .pass_o          (pass4),
      .cov_o           (cov4),
      .chk_cnt_o       (chk4),
      .err_cnt_o       (err4),
      .first_err_vld_o (fev4),
      .first_err_o     (fe4)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad   = 0;

   // Reference model: phase 0=idle 1=run 2=done, plus raw (unsaturated) tallies.
   int         m_ph;
   int         m_n;
   int         m_e;
   logic [3:0] m_cov;
   bit         m_fev;
   logic [2:0] m_fe;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      m_n = 0; m_e = 0; m_cov = 4'h0; m_fev = 0; m_fe = 3'b000;
   endtask

   task automatic model_step();
      if (m_ph == 1) begin
         if (sif.valid_i) begin
            m_n++;
            m_cov[{sif.A_i, sif.B_i}] = 1'b1;
            if (sif.F_i != !(sif.A_i && sif.B_i)) begin
               m_e++;
               if (!m_fev) begin
                  m_fev = 1;
                  m_fe  = {sif.A_i, sif.B_i, sif.F_i};
               end
            end
         end
         if (sif.stop_i) m_ph = 2;
      end else if (sif.start_i) begin
         m_ph = 1;
         model_clear();
      end
   endtask

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic cmp_dut(input string tag, input int mx,
                          input logic busy, input logic done, input logic pass,
                          input logic [3:0] cov, input logic [31:0] chk,
                          input logic [31:0] err, input logic fev, input logic [2:0] fe);
      check({tag, ".busy"}, 32'(busy), 32'(m_ph == 1));
      check({tag, ".done"}, 32'(done), 32'(m_ph == 2));
      check({tag, ".pass"}, 32'(pass), 32'((m_ph == 2) && (m_e == 0) && (m_cov == 4'hF)));
      check({tag, ".cov"},  32'(cov),  32'(m_cov));
      check({tag, ".chk"},  chk,       32'(sat(m_n, mx)));
      check({tag, ".err"},  err,       32'(sat(m_e, mx)));
      check({tag, ".fev"},  32'(fev),  32'(m_fev));
      check({tag, ".fe"},   32'(fe),   32'(m_fe));
   endtask

   task automatic check_all(input string tag);
      cmp_dut({tag, "/w8"}, 255, busy8, done8, pass8, cov8, 32'(chk8), 32'(err8), fev8, fe8);
      cmp_dut({tag, "/w4"}, 15,  busy4, done4, pass4, cov4, 32'(chk4), 32'(err4), fev4, fe4);
   endtask

   task automatic drive(input logic st, input logic sp, input logic v,
                        input logic a, input logic b, input logic f);
      sif.start_i = st; sif.stop_i = sp; sif.valid_i = v;
      sif.A_i = a; sif.B_i = b; sif.F_i = f;
   endtask

   // One rising edge: model advances on the same inputs, outputs sampled 1 unit later.
   task automatic cyc();
      @(posedge clk_i);
      model_step();
      #1;
   endtask

   typedef struct {
      logic       st, sp, v, a, b, f;
      logic       e_busy, e_done, e_pass, e_fev;
      logic [3:0] e_chk, e_err, e_cov;
      logic [2:0] e_fe;
   } vec_t;

   vec_t vt[18];

   initial begin
      // st sp v a b f  | busy done pass fev chk err cov fe
      vt[0]  = '{1,0,1,0,0,0, 1,0,0,0, 0,0,4'h0,3'b000};
      vt[1]  = '{0,0,1,0,0,1, 1,0,0,0, 1,0,4'h1,3'b000};
      vt[2]  = '{0,0,1,1,0,1, 1,0,0,0, 2,0,4'h5,3'b000};
      vt[3]  = '{0,0,1,0,1,1, 1,0,0,0, 3,0,4'h7,3'b000};
      vt[4]  = '{0,1,1,1,1,0, 0,1,1,0, 4,0,4'hF,3'b000};
      vt[5]  = '{0,1,1,1,1,1, 0,1,1,0, 4,0,4'hF,3'b000};
      vt[6]  = '{1,0,1,0,0,0, 1,0,0,0, 0,0,4'h0,3'b000};
      vt[7]  = '{0,0,1,0,0,0, 1,0,0,1, 1,1,4'h1,3'b000};
      vt[8]  = '{0,0,1,1,0,1, 1,0,0,1, 2,1,4'h5,3'b000};
      vt[9]  = '{0,0,1,0,1,1, 1,0,0,1, 3,1,4'h7,3'b000};
      vt[10] = '{0,0,1,1,1,1, 1,0,0,1, 4,2,4'hF,3'b000};
      vt[11] = '{0,1,0,0,0,0, 0,1,0,1, 4,2,4'hF,3'b000};
      vt[12] = '{1,0,0,0,0,0, 1,0,0,0, 0,0,4'h0,3'b000};
      vt[13] = '{0,0,1,0,0,1, 1,0,0,0, 1,0,4'h1,3'b000};
      vt[14] = '{0,0,1,1,1,0, 1,0,0,0, 2,0,4'h9,3'b000};
      vt[15] = '{0,1,0,0,0,0, 0,1,0,0, 2,0,4'h9,3'b000};
      vt[16] = '{1,0,0,0,0,0, 1,0,0,0, 0,0,4'h0,3'b000};
      vt[17] = '{1,1,0,0,0,0, 0,1,0,0, 0,0,4'h0,3'b000};

      drive(0, 0, 0, 0, 0, 0);
      rst_n_i = 1'b0;
      m_ph = 0;
      model_clear();
      #1;
      check_all("reset");
      #1 rst_n_i = 1'b1;

      // Directed table against hand-derived constants and the model.
      for (int i = 0; i < 18; i++) begin
         drive(vt[i].st, vt[i].sp, vt[i].v, vt[i].a, vt[i].b, vt[i].f);
         cyc();
         check($sformatf("vec%0d.busy", i), 32'(busy8), 32'(vt[i].e_busy));
         check($sformatf("vec%0d.done", i), 32'(done8), 32'(vt[i].e_done));
         check($sformatf("vec%0d.pass", i), 32'(pass8), 32'(vt[i].e_pass));
         check($sformatf("vec%0d.fev",  i), 32'(fev8),  32'(vt[i].e_fev));
         check($sformatf("vec%0d.chk",  i), 32'(chk8),  32'(vt[i].e_chk));
         check($sformatf("vec%0d.err",  i), 32'(err8),  32'(vt[i].e_err));
         check($sformatf("vec%0d.cov",  i), 32'(cov8),  32'(vt[i].e_cov));
         check($sformatf("vec%0d.fe",   i), 32'(fe8),   32'(vt[i].e_fe));
         check_all($sformatf("vec%0d", i));
      end

      // Saturation: 20 mismatching (1,1,1) samples.
      drive(1, 0, 0, 0, 0, 0); cyc();
      for (int i = 0; i < 20; i++) begin
         drive(0, 0, 1, 1, 1, 1); cyc();
      end
      drive(0, 1, 0, 0, 0, 0); cyc();
      check("sat.w4.chk", 32'(chk4), 32'hF);
      check("sat.w4.err", 32'(err4), 32'hF);
      check("sat.w4.pass", 32'(pass4), 32'h0);
      check("sat.w8.chk", 32'(chk8), 32'd20);
      check("sat.w8.err", 32'(err8), 32'd20);
      check("sat.fe", 32'(fe4), 32'b111);
      check_all("sat");
      drive(1, 0, 0, 0, 0, 0); cyc();
      check("sat.clr.chk", 32'(chk4), 32'h0);
      check("sat.clr.err", 32'(err4), 32'h0);
      check_all("sat_clr");

      // Reset mid-run after 2 samples, pulsed between edges.
      drive(0, 0, 1, 0, 0, 1); cyc();
      drive(0, 0, 1, 1, 1, 1); cyc();
      drive(0, 0, 0, 0, 0, 0);
      #2 rst_n_i = 1'b0;
      #1;
      m_ph = 0;
      model_clear();
      check("rst.busy", 32'(busy8), 32'h0);
      check("rst.chk", 32'(chk8), 32'h0);
      check("rst.fev", 32'(fev4), 32'h0);
      check_all("rst_mid");
      #2 rst_n_i = 1'b1;
      cyc();
      check_all("rst_idle");

      // Full passing run after reset.
      drive(1, 0, 0, 0, 0, 0); cyc();
      drive(0, 0, 1, 0, 0, 1); cyc();
      drive(0, 0, 1, 1, 0, 1); cyc();
      drive(0, 0, 1, 0, 1, 1); cyc();
      drive(0, 0, 1, 1, 1, 0); cyc();
      drive(0, 1, 0, 0, 0, 0); cyc();
      check("rerun.pass", 32'(pass8), 32'h1);
      check("rerun.chk", 32'(chk8), 32'd4);
      check_all("rerun");

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         logic a, b;
         a = 1'($urandom_range(0, 1));
         b = 1'($urandom_range(0, 1));
         drive(1'($urandom_range(0, 99) < 5),
               1'($urandom_range(0, 99) < 4),
               1'($urandom_range(0, 99) < 75),
               a, b,
               ($urandom_range(0, 99) < 92) ? ~(a & b) : (a & b));
         cyc();
         check_all($sformatf("rnd%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
